// File: rtl/disturb_burst_ctrl.sv
// Burst-train enable generator for the PN disturber: N bursts of on_len cycles separated by off_len idle cycles.
// All outputs are registered; disturb_en rises one cycle after an accepted start, and start is ignored while busy.
module disturb_burst_ctrl #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] on_len,
  input  logic [LEN_W-1:0] off_len,
  input  logic [CNT_W-1:0] n_bursts,
  output logic             disturb_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] burst_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_FIN
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [LEN_W-1:0] on_q, on_nxt;
  logic [LEN_W-1:0] off_q, off_nxt;
  logic [CNT_W-1:0] n_q, n_nxt;
  logic [CNT_W-1:0] idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      on_q       <= '0;
      off_q      <= '0;
      n_q        <= '0;
      burst_idx  <= '0;
      disturb_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      on_q       <= on_nxt;
      off_q      <= off_nxt;
      n_q        <= n_nxt;
      burst_idx  <= idx_nxt;
      // Outputs are decoded from the next state so they register in step with it.
      disturb_en <= (state_nxt == S_ON);
      busy       <= (state_nxt == S_ON) || (state_nxt == S_OFF);
      done       <= (state_nxt == S_FIN);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    on_nxt    = on_q;
    off_nxt   = off_q;
    n_nxt     = n_q;
    idx_nxt   = burst_idx;

    if (abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          if (state == S_FIN) begin
            state_nxt = S_IDLE;
          end
          // FIN reports busy=0, so a new train can be launched straight out of it.
          if (start) begin
            on_nxt  = on_len;
            off_nxt = (off_len == '0) ? LEN_W'(1) : off_len;
            n_nxt   = n_bursts;
            idx_nxt = '0;
            if (on_len == '0 || n_bursts == '0) begin
              state_nxt = S_FIN;
            end else begin
              state_nxt = S_ON;
              cnt_nxt   = on_len - LEN_W'(1);
            end
          end
        end

        S_ON: begin
          if (cnt == '0) begin
            if (burst_idx == n_q - CNT_W'(1)) begin
              state_nxt = S_FIN;
            end else begin
              state_nxt = S_OFF;
              cnt_nxt   = off_q - LEN_W'(1);
            end
          end else begin
            cnt_nxt = cnt - LEN_W'(1);
          end
        end

        S_OFF: begin
          if (cnt == '0) begin
            state_nxt = S_ON;
            cnt_nxt   = on_q - LEN_W'(1);
            idx_nxt   = burst_idx + CNT_W'(1);
          end else begin
            cnt_nxt = cnt - LEN_W'(1);
          end
        end

        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disturb_burst_ctrl.sv
// Bench for disturb_burst_ctrl: directed scenarios plus randomized traffic against a timeline model.
module tb_disturb_burst_ctrl;
  localparam int LEN_W = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [LEN_W-1:0] on_len = '0;
  logic [LEN_W-1:0] off_len = '0;
  logic [CNT_W-1:0] n_bursts = '0;
  logic             disturb_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] burst_idx;

  int checks = 0;
  int errors = 0;

  disturb_burst_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .on_len    (on_len),
    .off_len   (off_len),
    .n_bursts  (n_bursts),
    .disturb_en(disturb_en),
    .busy      (busy),
    .done      (done),
    .burst_idx (burst_idx)
  );

  always #5 clk = ~clk;

  // Reference model: position k cycles after the accepted start edge maps onto a
  // fixed timeline of period on+off; busy lasts on*N + off*(N-1) cycles, then done.
  bit               m_active = 0;
  longint           m_on = 0, m_off = 0, m_n = 0, m_k = 0;
  logic             exp_en = 0, exp_busy = 0, exp_done = 0;
  logic [CNT_W-1:0] exp_idx = '0;

  task automatic model_eval();
    longint b, p;
    b = (m_on == 0 || m_n == 0) ? 0 : m_on * m_n + m_off * (m_n - 1);
    p = m_on + m_off;
    if (m_k <= b) begin
      exp_en   = ((m_k - 1) % p) < m_on;
      exp_busy = 1'b1;
      exp_done = 1'b0;
      exp_idx  = CNT_W'((m_k - 1) / p);
    end else if (m_k == b + 1) begin
      exp_en   = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b1;
    end else begin
      exp_en   = 1'b0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      m_active = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0;
      exp_en = 0; exp_busy = 0; exp_done = 0; exp_idx = '0;
    end else if (abort) begin
      m_active = 0;
      exp_en = 0; exp_busy = 0; exp_done = 0;
    end else if (start && !exp_busy) begin
      m_on = on_len;
      m_off = (off_len == 0) ? 1 : off_len;
      m_n = n_bursts;
      m_k = 1;
      m_active = 1;
      exp_idx = '0;
      model_eval();
    end else if (m_active) begin
      m_k++;
      model_eval();
    end
  end

  task automatic launch(input int on, input int off, input int n);
    on_len = LEN_W'(on); off_len = LEN_W'(off); n_bursts = CNT_W'(n);
    start = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({disturb_en, busy, done, burst_idx} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0", {disturb_en, busy, done, burst_idx});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({disturb_en, busy, done, burst_idx} !== 11'd0) begin
      errors++;
      $display("FAIL reset_release got %b exp 0", {disturb_en, busy, done, burst_idx});
    end
  endtask

  task automatic test_basic();
    logic [10:0] e;
    launch(4, 3, 2);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 2) begin on_len = 16'd50; off_len = 16'd9; n_bursts = 8'd7; end
      e = {((k >= 1 && k <= 4) || (k >= 8 && k <= 11)), (k <= 11), (k == 12),
           CNT_W'((k >= 8) ? 1 : 0)};
      checks++;
      if ({disturb_en, busy, done, burst_idx} !== e) begin
        errors++;
        $display("FAIL basic k=%0d got %b exp %b", k, {disturb_en, busy, done, burst_idx}, e);
      end
    end
  endtask

  task automatic test_zero();
    logic [10:0] e;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) launch(0, 3, 5); else launch(7, 3, 0);
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        start = 1'b0;
        e = {1'b0, 1'b0, (k == 1), CNT_W'(0)};
        checks++;
        if ({disturb_en, busy, done, burst_idx} !== e) begin
          errors++;
          $display("FAIL zero case=%0d k=%0d got %b exp %b", c, k, {disturb_en, busy, done, burst_idx}, e);
        end
      end
    end
    launch(2, 0, 3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      e = {(k <= 8 && ((k - 1) % 3) < 2), (k <= 8), (k == 9), CNT_W'((k <= 8) ? (k - 1) / 3 : 2)};
      checks++;
      if ({disturb_en, busy, done, burst_idx} !== e) begin
        errors++;
        $display("FAIL zero_gap k=%0d got %b exp %b", k, {disturb_en, busy, done, burst_idx}, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [10:0] e;
    launch(100, 1, 1);
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      e = (k <= 40) ? {1'b1, 1'b1, 1'b0, CNT_W'(0)} : 11'd0;
      checks++;
      if ({disturb_en, busy, done, burst_idx} !== e) begin
        errors++;
        $display("FAIL abort k=%0d got %b exp %b", k, {disturb_en, busy, done, burst_idx}, e);
      end
      if (k == 40) abort = 1'b1;
    end
    launch(5, 1, 1);
    abort = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if ({disturb_en, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL abort_vs_start k=%0d got %b exp 000", k, {disturb_en, busy, done});
      end
    end
    launch(3, 2, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      e = {(k <= 3), (k <= 3), (k == 4), CNT_W'(0)};
      checks++;
      if ({disturb_en, busy, done, burst_idx} !== e) begin
        errors++;
        $display("FAIL abort_rerun k=%0d got %b exp %b", k, {disturb_en, busy, done, burst_idx}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] e;
    launch(2, 1, 2);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 5)      e = {(((k - 1) % 3) < 2), 1'b1, 1'b0, CNT_W'((k - 1) / 3)};
      else if (k == 6) e = {1'b0, 1'b0, 1'b1, CNT_W'(1)};
      else             e = {1'b1, 1'b1, 1'b0, CNT_W'(0)};
      checks++;
      if ({disturb_en, busy, done, burst_idx} !== e) begin
        errors++;
        $display("FAIL back_to_back k=%0d got %b exp %b", k, {disturb_en, busy, done, burst_idx}, e);
      end
    end
    start = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_ignore();
    logic [10:0] e;
    launch(3, 2, 3);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start = (k == 4);
      if (k == 4) begin on_len = 16'd9; off_len = 16'd0; n_bursts = 8'd1; end
      e = {(k <= 13 && ((k - 1) % 5) < 3), (k <= 13), (k == 14), CNT_W'((k <= 13) ? (k - 1) / 5 : 2)};
      checks++;
      if ({disturb_en, busy, done, burst_idx} !== e) begin
        errors++;
        $display("FAIL ignore k=%0d got %b exp %b", k, {disturb_en, busy, done, burst_idx}, e);
      end
    end
  endtask

  task automatic test_async_reset();
    launch(3, 5, 3);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if ({busy, burst_idx} !== {1'b1, CNT_W'(1)}) begin
      errors++;
      $display("FAIL async_pre got %b exp %b", {busy, burst_idx}, {1'b1, CNT_W'(1)});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({disturb_en, busy, done, burst_idx} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset got %b exp 0", {disturb_en, busy, done, burst_idx});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({disturb_en, busy, done, burst_idx} !== 11'd0) begin
        errors++;
        $display("FAIL async_idle got %b exp 0", {disturb_en, busy, done, burst_idx});
      end
    end
  endtask

  task automatic test_max_bursts();
    launch(1, 1, 255);
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({disturb_en, busy, done, burst_idx} !== {exp_en, exp_busy, exp_done, exp_idx}) begin
        errors++;
        $display("FAIL max_bursts k=%0d got %b exp %b", k, {disturb_en, busy, done, burst_idx},
                 {exp_en, exp_busy, exp_done, exp_idx});
      end
      if (k == 510) begin
        checks++;
        if ({done, burst_idx} !== {1'b1, 8'd254}) begin
          errors++;
          $display("FAIL max_done got %b exp %b", {done, burst_idx}, {1'b1, 8'd254});
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++;
      if ({disturb_en, busy, done, burst_idx} !== {exp_en, exp_busy, exp_done, exp_idx}) begin
        errors++;
        $display("FAIL random c=%0d got %b exp %b", c, {disturb_en, busy, done, burst_idx},
                 {exp_en, exp_busy, exp_done, exp_idx});
      end
      on_len   = LEN_W'($urandom_range(0, 6));
      off_len  = LEN_W'($urandom_range(0, 4));
      n_bursts = CNT_W'($urandom_range(0, 4));
      start    = ($urandom_range(0, 5) == 0);
      abort    = ($urandom_range(0, 29) == 0);
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (60) @(negedge clk);
  endtask

  task automatic test_pn_integration();
    logic [14:0] lfsr;
    logic [15:0] pat [4];
    logic [15:0] cur;
    int          pos, nb;
    lfsr = 15'h0001; pos = 0; nb = 0; cur = '0;
    launch(16, 3, 4);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (disturb_en) begin
        if (pos < 16) cur[pos] = lfsr[14];
        lfsr = {lfsr[13:0], lfsr[14] ^ lfsr[13]};
        pos++;
      end else begin
        if (pos > 0) begin
          checks++;
          if (pos != 16) begin
            errors++;
            $display("FAIL pn_len burst=%0d got %0d exp 16", nb, pos);
          end
          if (nb < 4) pat[nb] = cur;
          nb++;
        end
        lfsr = 15'h0001;
        pos = 0;
      end
    end
    checks++;
    if (nb != 4) begin
      errors++;
      $display("FAIL pn_bursts got %0d exp 4", nb);
    end
    for (int b = 1; b < 4 && b < nb; b++) begin
      checks++;
      if (pat[b] !== pat[0]) begin
        errors++;
        $display("FAIL pn_pattern burst=%0d got %h exp %h", b, pat[b], pat[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_abort();
    test_back_to_back();
    test_ignore();
    test_async_reset();
    test_max_bursts();
    test_random();
    test_pn_integration();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disturb_burst_ctrl.md
Name: disturb_burst_ctrl

Overview:
- Upstream controller for the PN noise disturber stage. Drives that stage's active-high enable input with a programmed train of bursts: N bursts, each ON_LEN cycles long, separated by OFF_LEN idle cycles.
- Enable is guaranteed low for at least one cycle between bursts. The disturber therefore reloads its PN seed, and every burst carries an identical chip sequence.
- Started by a one-cycle trigger from the tag control logic. Reports busy and done.

Parameters:
- LEN_W, 16, width of the on_len and off_len inputs and of the internal cycle counter.
- CNT_W, 8, width of n_bursts and burst_idx.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle trigger; sampled only when busy=0.
- abort  in  1  synchronous cancel; has priority over start and over every state transition.
- on_len  in  LEN_W  ON duration per burst, in clk cycles; latched at start.
- off_len  in  LEN_W  gap between bursts, in clk cycles; latched at start; a value of 0 is treated as 1.
- n_bursts  in  CNT_W  number of bursts; latched at start.
- disturb_en  out  1  registered enable to the disturber.
- busy  out  1  high from the cycle after an accepted start until the sequence completes or is aborted.
- done  out  1  one-cycle pulse on normal completion.
- burst_idx  out  CNT_W  0-based index of the current or most recent burst.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, disturb_en=0, busy=0, done=0, burst_idx=0, counter=0, latched lengths=0.
- States: IDLE, ON, OFF, FIN.
- IDLE:
  - start=1 at edge t latches on_len, off_len (0 becomes 1) and n_bursts, and clears burst_idx to 0.
  - If latched on_len==0 or n_bursts==0, go to FIN.
  - Otherwise go to ON with counter=on_len-1.
- ON:
  - disturb_en=1, busy=1.
  - disturb_en is high in exactly cycles t+1 .. t+on_len for the first burst.
  - When counter==0:
    - If burst_idx==n_bursts-1, go to FIN.
    - Otherwise go to OFF with counter=off_len-1.
  - Otherwise decrement the counter.
- OFF:
  - disturb_en=0, busy=1.
  - When counter==0: burst_idx increments, counter=on_len-1, go to ON.
  - Otherwise decrement the counter.
- FIN:
  - Lasts exactly one cycle.
  - done=1, busy=0, disturb_en=0; then go to IDLE.
  - start is accepted in FIN (busy=0) exactly as in IDLE, so back-to-back sequences are allowed.
- Total busy length: on_len*N + off_len_eff*(N-1) cycles. done follows the last ON cycle immediately.
- abort=1 in any state:
  - Next state is IDLE; disturb_en=0 and busy=0 from the following cycle.
  - done is not pulsed; burst_idx holds its value.
  - abort and start asserted in the same cycle: abort wins and start is dropped.
- start while busy=1: ignored; latched values are unchanged.
- Input changes on on_len, off_len and n_bursts after the start cycle have no effect on the running sequence.
- All outputs are registered and glitch-free, with no combinational path from any input to any output.
- Counter arithmetic is unsigned. on_len values up to 2^LEN_W-1 are supported without wrap. n_bursts=2^CNT_W-1 produces 255 bursts for the default width.
- rst_n asserted mid-burst: disturb_en drops immediately (asynchronous); no done pulse.

Test Plan:
- Basic train: on_len=4, off_len=3, n_bursts=2, start at t=10 → disturb_en high at t=11..14 and t=18..21, low at t=15..17; burst_idx=1 at t=18; done=1 only at t=22; busy high t=11..21.
- Zero cases:
  - on_len=0, n_bursts=5 → no disturb_en, done at t+1, busy stays 0.
  - n_bursts=0 → same response.
  - off_len=0, on_len=2, n_bursts=3 → exactly a 1-cycle gap between bursts; 3 bursts of 2 cycles each.
- Abort: on_len=100, n_bursts=1; abort during ON cycle 40 → disturb_en=0 next cycle, done never pulses, busy=0; a subsequent start runs normally.
- Retrigger and ignore:
  - start held high for the whole run → a second sequence starts in the FIN cycle, and disturb_en rises the cycle after done.
  - start pulsed mid-sequence with different lengths → no effect on the running sequence.
- Async reset: pull rst_n low mid-OFF (asynchronously, between edges) → all outputs 0 without waiting for a clock edge; after release, IDLE.
- Integration with the disturber (default seed): every burst of on_len=16 yields an identical 16-chip s_out pattern, compared burst-to-burst.
